interrupt_controller: RTL and testbench

Interrupt source for the pipeline: latches external interrupt lines into a pending register and arbitrates them by fixed priority. Raises `interrupt_ctrl` toward the hazard detection unit and waits for its `interrupt_en` grant. On grant it redirects fetch to a vector, captures the return PC and cause, then tracks the handler until a return instruction restores the PC. It sits beside the hazard unit and drives the PC-select path in IF.

---
 rtl/irq_pkg.sv | 17 +
 rtl/irq_priority_encoder.sv | 20 ++
 rtl/interrupt_controller.sv | 131 +++++++++++++
 tb/tb_interrupt_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam logic [31:0] VECTOR_BASE_DEF = 32'h0000_0100;

    // Cause/ID width; one bit minimum so a single-line build still has a field.
    function automatic int IRQ_ID_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Lowest-index-first priority encoder over the eligible interrupt set.
module irq_priority_encoder #(
    parameter int N    = 8,
    parameter int ID_W = 3
) (
    input  logic [N-1:0]    i_req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    always_comb begin
        valid = |i_req;
        id    = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[k]) id = ID_W'(k);
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-captured, fixed-priority interrupt controller: requests a flush from the
// hazard unit, redirects fetch to a vector, and restores the PC on return.
module interrupt_controller
    import irq_pkg::*;
#(
    parameter int              NUM_IRQ       = 8,
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] VECTOR_BASE   = XLEN'(VECTOR_BASE_DEF),
    parameter int              VECTOR_STRIDE = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IRQ-1:0]           irq_lines,
    input  logic                         global_en,
    input  logic                         mask_we,
    input  logic [NUM_IRQ-1:0]           mask_wdata,
    input  logic                         interrupt_en,
    input  logic [XLEN-1:0]              pc_ID,
    input  logic                         mret_EXE,
    output logic                         interrupt_ctrl,
    output logic                         irq_pc_sel,
    output logic [XLEN-1:0]              irq_target_pc,
    output logic [XLEN-1:0]              epc,
    output logic [IRQ_ID_W(NUM_IRQ)-1:0] irq_cause,
    output logic                         in_service
);

    localparam int ID_W = IRQ_ID_W(NUM_IRQ);

    irq_state_t         r_state;
    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_mask;
    logic [ID_W-1:0]    r_req_id;
    logic [ID_W-1:0]    r_cause;
    logic [XLEN-1:0]    r_epc;
    logic               r_ctrl;
    logic               r_in_service;

    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_elig;
    logic               w_enc_valid;
    logic [ID_W-1:0]    w_enc_id;
    logic               w_req_live;
    logic               w_grant;
    logic               w_ret;
    logic [XLEN-1:0]    w_vector;

    assign w_rise     = irq_lines & ~r_prev;
    assign w_elig     = global_en ? (r_pending & r_mask) : '0;
    assign w_req_live = r_pending[r_req_id] & r_mask[r_req_id] & global_en;
    assign w_grant    = r_ctrl & interrupt_en;
    assign w_ret      = r_in_service & mret_EXE;
    assign w_clr      = w_grant ? (NUM_IRQ'(1) << r_req_id) : '0;
    assign w_vector   = VECTOR_BASE + XLEN'(r_req_id) * XLEN'(VECTOR_STRIDE);

    irq_priority_encoder #(
        .N    (NUM_IRQ),
        .ID_W (ID_W)
    ) u_prio (
        .i_req (w_elig),
        .valid (w_enc_valid),
        .id    (w_enc_id)
    );

    // A fresh edge outranks the grant-clear on the same bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_prev    <= irq_lines;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (mask_we) r_mask <= mask_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_req_id     <= '0;
            r_cause      <= '0;
            r_epc        <= '0;
            r_ctrl       <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_enc_valid) begin
                        r_state  <= REQUEST;
                        r_req_id <= w_enc_id;
                        r_ctrl   <= 1'b1;
                    end
                end
                REQUEST: begin
                    if (interrupt_en) begin
                        r_state      <= SERVICE;
                        r_epc        <= pc_ID;
                        r_cause      <= r_req_id;
                        r_ctrl       <= 1'b0;
                        r_in_service <= 1'b1;
                    end else if (!w_req_live) begin
                        r_state <= IDLE;
                        r_ctrl  <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (mret_EXE) begin
                        r_state      <= IDLE;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_ctrl       <= 1'b0;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt_ctrl = r_ctrl;
    assign in_service     = r_in_service;
    assign irq_pc_sel     = w_grant | w_ret;
    assign irq_target_pc  = w_grant ? w_vector : (w_ret ? r_epc : '0);
    assign epc            = r_epc;
    assign irq_cause      = r_cause;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus a randomized run against a behavioural model.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_lines;
    logic        global_en;
    logic        mask_we;
    logic [7:0]  mask_wdata;
    logic        interrupt_en;
    logic [31:0] pc_ID;
    logic        mret_EXE;
    logic        interrupt_ctrl;
    logic        irq_pc_sel;
    logic [31:0] irq_target_pc;
    logic [31:0] epc;
    logic [2:0]  irq_cause;
    logic        in_service;

    int n_cmp = 0;
    int n_bad = 0;

    interrupt_controller dut (
        .clk            (clk),
        .rst            (rst),
        .irq_lines      (irq_lines),
        .global_en      (global_en),
        .mask_we        (mask_we),
        .mask_wdata     (mask_wdata),
        .interrupt_en   (interrupt_en),
        .pc_ID          (pc_ID),
        .mret_EXE       (mret_EXE),
        .interrupt_ctrl (interrupt_ctrl),
        .irq_pc_sel     (irq_pc_sel),
        .irq_target_pc  (irq_target_pc),
        .epc            (epc),
        .irq_cause      (irq_cause),
        .in_service     (in_service)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 = idle, 1 = requesting, 2 = in handler.
    logic [7:0]  m_prev, m_pend, m_mask;
    int          m_phase, m_req;
    logic [31:0] m_epc;
    int          m_cause;
    logic        e_ctrl, e_sel, e_svc;
    logic [31:0] e_tgt;

    task automatic model_reset();
        m_prev = 0; m_pend = 0; m_mask = 0;
        m_phase = 0; m_req = 0; m_epc = 0; m_cause = 0;
    endtask

    task automatic model_eval();
        e_ctrl = (m_phase == 1);
        e_svc  = (m_phase == 2);
        e_sel  = 1'b0;
        e_tgt  = 32'h0;
        if (m_phase == 1 && interrupt_en) begin
            e_sel = 1'b1;
            e_tgt = 32'h100 + m_req * 4;
        end else if (m_phase == 2 && mret_EXE) begin
            e_sel = 1'b1;
            e_tgt = m_epc;
        end
    endtask

    task automatic model_step();
        logic [7:0] rise, clr, elig;
        rise = irq_lines & ~m_prev;
        clr  = 0;
        elig = global_en ? (m_pend & m_mask) : 8'h0;
        if (m_phase == 0) begin
            for (int k = 7; k >= 0; k--) if (elig[k]) m_req = k;
            if (elig != 0) m_phase = 1;
        end else if (m_phase == 1) begin
            if (interrupt_en) begin
                m_epc = pc_ID; m_cause = m_req; clr[m_req] = 1'b1; m_phase = 2;
            end else if (!(m_pend[m_req] && m_mask[m_req] && global_en)) begin
                m_phase = 0;
            end
        end else if (mret_EXE) begin
            m_phase = 0;
        end
        m_pend = (m_pend & ~clr) | rise;
        if (mask_we) m_mask = mask_wdata;
        m_prev = irq_lines;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_lines = 0; global_en = 0; mask_we = 0; mask_wdata = 0;
        interrupt_en = 0; pc_ID = 0; mret_EXE = 0;
        model_reset();
        #1;
        n_cmp++; if (interrupt_ctrl !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b want 0", interrupt_ctrl); end
        n_cmp++; if (irq_pc_sel !== 1'b0) begin n_bad++; $display("FAIL reset_sel: got %b want 0", irq_pc_sel); end
        n_cmp++; if (irq_target_pc !== 32'h0) begin n_bad++; $display("FAIL reset_tgt: got %h want 0", irq_target_pc); end
        n_cmp++; if (epc !== 32'h0) begin n_bad++; $display("FAIL reset_epc: got %h want 0", epc); end
        n_cmp++; if (irq_cause !== 3'd0) begin n_bad++; $display("FAIL reset_cause: got %0d want 0", irq_cause); end
        n_cmp++; if (in_service !== 1'b0) begin n_bad++; $display("FAIL reset_svc: got %b want 0", in_service); end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_single_irq();
        global_en = 1; mask_we = 1; mask_wdata = 8'hFF; cyc();
        mask_we = 0; irq_lines[3] = 1; cyc();
        irq_lines[3] = 0; cyc();
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (interrupt_ctrl !== 1'b1) begin n_bad++; $display("FAIL single_hold: got %b want 1", interrupt_ctrl); end
            cyc();
        end
        interrupt_en = 1; pc_ID = 32'h40; #1;
        n_cmp++; if (irq_pc_sel !== 1'b1) begin n_bad++; $display("FAIL single_sel: got %b want 1", irq_pc_sel); end
        n_cmp++; if (irq_target_pc !== 32'h10C) begin n_bad++; $display("FAIL single_tgt: got %h want 10c", irq_target_pc); end
        cyc();
        interrupt_en = 0; #1;
        n_cmp++; if (epc !== 32'h40) begin n_bad++; $display("FAIL single_epc: got %h want 40", epc); end
        n_cmp++; if (irq_cause !== 3'd3) begin n_bad++; $display("FAIL single_cause: got %0d want 3", irq_cause); end
        n_cmp++; if (in_service !== 1'b1) begin n_bad++; $display("FAIL single_svc: got %b want 1", in_service); end
        mret_EXE = 1; #1;
        n_cmp++; if (irq_target_pc !== 32'h40) begin n_bad++; $display("FAIL single_ret: got %h want 40", irq_target_pc); end
        cyc();
        mret_EXE = 0;
    endtask

    task automatic test_priority();
        irq_lines[5] = 1; irq_lines[2] = 1; cyc();
        irq_lines = 0; cyc();
        interrupt_en = 1; pc_ID = 32'h80; #1;
        n_cmp++; if (irq_target_pc !== 32'h108) begin n_bad++; $display("FAIL prio_first: got %h want 108", irq_target_pc); end
        cyc();
        interrupt_en = 0; mret_EXE = 1; cyc();
        mret_EXE = 0; cyc();
        n_cmp++; if (interrupt_ctrl !== 1'b1) begin n_bad++; $display("FAIL prio_second_req: got %b want 1", interrupt_ctrl); end
        interrupt_en = 1; #1;
        n_cmp++; if (irq_target_pc !== 32'h114) begin n_bad++; $display("FAIL prio_second: got %h want 114", irq_target_pc); end
        cyc();
        interrupt_en = 0; mret_EXE = 1; cyc();
        mret_EXE = 0;
    endtask

    task automatic test_withdrawal();
        irq_lines[1] = 1; cyc();
        irq_lines[1] = 0; cyc();
        n_cmp++; if (interrupt_ctrl !== 1'b1) begin n_bad++; $display("FAIL wd_req: got %b want 1", interrupt_ctrl); end
        mask_we = 1; mask_wdata = 8'h00; cyc();
        mask_we = 0; cyc();
        n_cmp++; if (interrupt_ctrl !== 1'b0) begin n_bad++; $display("FAIL wd_drop: got %b want 0", interrupt_ctrl); end
        cyc();
        n_cmp++; if (interrupt_ctrl !== 1'b0) begin n_bad++; $display("FAIL wd_stay_idle: got %b want 0", interrupt_ctrl); end
        mask_we = 1; mask_wdata = 8'hFF; cyc();
        mask_we = 0; cyc();
        n_cmp++; if (interrupt_ctrl !== 1'b1) begin n_bad++; $display("FAIL wd_rereq: got %b want 1", interrupt_ctrl); end
        interrupt_en = 1; pc_ID = 32'h200; #1;
        n_cmp++; if (irq_target_pc !== 32'h104) begin n_bad++; $display("FAIL wd_tgt: got %h want 104", irq_target_pc); end
        cyc();
        interrupt_en = 0;
    endtask

    task automatic test_no_nesting();
        irq_lines[0] = 1; cyc();
        irq_lines[0] = 0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (interrupt_ctrl !== 1'b0) begin n_bad++; $display("FAIL nest_ctrl: got %b want 0", interrupt_ctrl); end
            cyc();
        end
        mret_EXE = 1; #1;
        n_cmp++; if (irq_pc_sel !== 1'b1) begin n_bad++; $display("FAIL nest_ret_sel: got %b want 1", irq_pc_sel); end
        n_cmp++; if (irq_target_pc !== 32'h200) begin n_bad++; $display("FAIL nest_ret_tgt: got %h want 200", irq_target_pc); end
        cyc();
        mret_EXE = 0; #1;
        n_cmp++; if (interrupt_ctrl !== 1'b0) begin n_bad++; $display("FAIL nest_idle: got %b want 0", interrupt_ctrl); end
        cyc();
        n_cmp++; if (interrupt_ctrl !== 1'b1) begin n_bad++; $display("FAIL nest_line0_req: got %b want 1", interrupt_ctrl); end
        interrupt_en = 1; pc_ID = 32'h250; #1;
        n_cmp++; if (irq_target_pc !== 32'h100) begin n_bad++; $display("FAIL nest_line0_tgt: got %h want 100", irq_target_pc); end
        cyc();
        interrupt_en = 0;
    endtask

    task automatic test_collision_reset();
        mret_EXE = 1; cyc();
        mret_EXE = 0; irq_lines[4] = 1; cyc();
        irq_lines[4] = 0; cyc();
        n_cmp++; if (interrupt_ctrl !== 1'b1) begin n_bad++; $display("FAIL col_req: got %b want 1", interrupt_ctrl); end
        irq_lines[4] = 1; interrupt_en = 1; pc_ID = 32'h300; #1;
        n_cmp++; if (irq_target_pc !== 32'h110) begin n_bad++; $display("FAIL col_tgt: got %h want 110", irq_target_pc); end
        cyc();
        interrupt_en = 0; #1;
        n_cmp++; if (irq_cause !== 3'd4) begin n_bad++; $display("FAIL col_cause: got %0d want 4", irq_cause); end
        mret_EXE = 1; cyc();
        mret_EXE = 0; cyc();
        n_cmp++; if (interrupt_ctrl !== 1'b1) begin n_bad++; $display("FAIL col_pending_kept: got %b want 1", interrupt_ctrl); end
        interrupt_en = 1; pc_ID = 32'h340; cyc();
        interrupt_en = 0; irq_lines[4] = 0; #1;
        n_cmp++; if (epc !== 32'h340) begin n_bad++; $display("FAIL col_epc: got %h want 340", epc); end
        mret_EXE = 1; #1;
        n_cmp++; if (irq_pc_sel !== 1'b1) begin n_bad++; $display("FAIL col_pre_rst_sel: got %b want 1", irq_pc_sel); end
        rst = 1; #1;
        n_cmp++; if (in_service !== 1'b0) begin n_bad++; $display("FAIL rst_svc: got %b want 0", in_service); end
        n_cmp++; if (irq_pc_sel !== 1'b0) begin n_bad++; $display("FAIL rst_sel: got %b want 0", irq_pc_sel); end
        n_cmp++; if (irq_target_pc !== 32'h0) begin n_bad++; $display("FAIL rst_tgt: got %h want 0", irq_target_pc); end
        n_cmp++; if (epc !== 32'h0) begin n_bad++; $display("FAIL rst_epc: got %h want 0", epc); end
        n_cmp++; if (irq_cause !== 3'd0) begin n_bad++; $display("FAIL rst_cause: got %0d want 0", irq_cause); end
        n_cmp++; if (interrupt_ctrl !== 1'b0) begin n_bad++; $display("FAIL rst_ctrl: got %b want 0", interrupt_ctrl); end
        @(negedge clk);
        rst = 0; mret_EXE = 0;
        model_reset();
        #1;
    endtask

    task automatic test_random();
        mask_we = 1; mask_wdata = 8'hFF; cyc();
        mask_we = 0;
        for (int i = 0; i < 600; i++) begin
            irq_lines    = 8'($urandom & $urandom & $urandom);
            global_en    = ($urandom_range(0, 9) != 0);
            mask_we      = ($urandom_range(0, 15) == 0);
            mask_wdata   = 8'($urandom);
            interrupt_en = $urandom_range(0, 1);
            mret_EXE     = ($urandom_range(0, 3) == 0);
            pc_ID        = $urandom;
            #1;
            model_eval();
            n_cmp++; if (interrupt_ctrl !== e_ctrl) begin n_bad++; $display("FAIL rnd_ctrl @%0d: got %b want %b", i, interrupt_ctrl, e_ctrl); end
            n_cmp++; if (irq_pc_sel !== e_sel) begin n_bad++; $display("FAIL rnd_sel @%0d: got %b want %b", i, irq_pc_sel, e_sel); end
            n_cmp++; if (irq_target_pc !== e_tgt) begin n_bad++; $display("FAIL rnd_tgt @%0d: got %h want %h", i, irq_target_pc, e_tgt); end
            n_cmp++; if (epc !== m_epc) begin n_bad++; $display("FAIL rnd_epc @%0d: got %h want %h", i, epc, m_epc); end
            n_cmp++; if (irq_cause !== 3'(m_cause)) begin n_bad++; $display("FAIL rnd_cause @%0d: got %0d want %0d", i, irq_cause, m_cause); end
            n_cmp++; if (in_service !== e_svc) begin n_bad++; $display("FAIL rnd_svc @%0d: got %b want %b", i, in_service, e_svc); end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_single_irq();
        test_priority();
        test_withdrawal();
        test_no_nesting();
        test_collision_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
